// File: rtl/fb_pkg.sv
// Shared geometry, request type and swap-state encoding for the frame-buffer arbiter.
package fb_pkg;

    localparam int unsigned IMG_W  = 320;
    localparam int unsigned IMG_H  = 240;
    localparam int unsigned ADDR_W = $clog2(IMG_W * IMG_H);

    typedef logic [ADDR_W-1:0] fb_addr_t;

    typedef struct packed {
        fb_addr_t   addr;
        logic [7:0] data;
    } wr_req_t;

    typedef enum logic {
        WRITING   = 1'b0,
        SWAP_WAIT = 1'b1
    } swap_state_t;

    // 2x2 upscale of the raw counts; y*320 is built as (y<<8)+(y<<6).
    function automatic fb_addr_t disp_addr(input logic [9:0] h, input logic [9:0] v);
        fb_addr_t x;
        fb_addr_t y;
        x = fb_addr_t'(h) >> 1;
        y = fb_addr_t'(v) >> 1;
        return (y << 8) + (y << 6) + x;
    endfunction

endpackage

// File: rtl/sync_fifo.sv
// Small synchronous FIFO, power-of-two depth, first-word-fall-through head.
module sync_fifo #(
    parameter  int unsigned WIDTH = 8,
    parameter  int unsigned DEPTH = 4,
    localparam int unsigned PTR_W = $clog2(DEPTH),
    localparam int unsigned CNT_W = $clog2(DEPTH + 1)
) (
    input  logic             clk_i,
    input  logic             rst_ni,
    input  logic             push_i,
    input  logic             pop_i,
    input  logic [WIDTH-1:0] data_i,
    output logic [WIDTH-1:0] data_o,
    output logic             full_o,
    output logic             empty_o,
    output logic [CNT_W-1:0] count_o
);

    logic [WIDTH-1:0] mem_q [DEPTH];
    logic [PTR_W-1:0] wrPtr_q, rdPtr_q;
    logic [CNT_W-1:0] count_q, count_d;
    logic             doPush, doPop;

    assign full_o  = (count_q == CNT_W'(DEPTH));
    assign empty_o = (count_q == '0);
    assign count_o = count_q;
    assign data_o  = mem_q[rdPtr_q];

    // A pop frees the slot a same-cycle push needs, so full+pop still accepts.
    assign doPush = push_i & (~full_o | pop_i);
    assign doPop  = pop_i & ~empty_o;

    always_comb begin
        count_d = count_q;
        if (doPush && !doPop) begin
            count_d = count_q + CNT_W'(1);
        end else if (doPop && !doPush) begin
            count_d = count_q - CNT_W'(1);
        end
    end

    always_ff @(posedge clk_i) begin
        if (doPush) begin
            mem_q[wrPtr_q] <= data_i;
        end
    end

    always_ff @(posedge clk_i) begin
        if (!rst_ni) begin
            wrPtr_q <= '0;
            rdPtr_q <= '0;
            count_q <= '0;
        end else begin
            if (doPush) wrPtr_q <= wrPtr_q + PTR_W'(1);
            if (doPop)  rdPtr_q <= rdPtr_q + PTR_W'(1);
            count_q <= count_d;
        end
    end

endmodule

// File: rtl/fb_access_arbiter.sv
// Single-port frame-buffer arbiter: display reads win during active video,
// buffered writer traffic drains otherwise, banks swap at frame boundaries.
module fb_access_arbiter
    import fb_pkg::*;
#(
    parameter int unsigned WFIFO_DEPTH = 4
) (
    input  logic              vgaClk,
    input  logic              rstN,
    input  logic [9:0]        hCount,
    input  logic [9:0]        vCount,
    input  logic              displayActive,
    input  logic              frameEnd,
    input  logic              wrValid,
    output logic              wrReady,
    input  logic [ADDR_W-1:0] wrAddr,
    input  logic [7:0]        wrData,
    input  logic              wrFrameDone,
    output logic              swapPending,
    output logic              dispBank,
    output logic [7:0]        pixelOut,
    output logic              pixelValid,
    output logic [ADDR_W:0]   memAddr,
    output logic              memWe,
    output logic [7:0]        memWdata,
    input  logic [7:0]        memRdata
);

    localparam int unsigned CNT_W = $clog2(WFIFO_DEPTH + 1);

    swap_state_t      state_q;
    logic             swapPending_q;
    logic             dispBank_q;
    logic             actD1_q;
    logic [7:0]       pixelOut_q;
    logic             pixelValid_q;
    logic [ADDR_W:0]  addrHold_q;
    logic [7:0]       wdataHold_q;

    fb_addr_t         dispAddr;
    wr_req_t          pushReq;
    wr_req_t          head;
    logic             fifoPush, fifoPop, fifoFull, fifoEmpty, drained;
    logic [CNT_W-1:0] fifoCount;

    assign wrReady  = ~fifoFull & ~swapPending_q & rstN;
    assign fifoPush = wrValid & wrReady;
    assign pushReq  = '{addr: wrAddr, data: wrData};
    assign dispAddr = disp_addr(hCount, vCount);

    // FIFO occupancy as it will be after this cycle's pop/push.
    assign drained = fifoEmpty | (fifoPop & ~fifoPush & (fifoCount == CNT_W'(1)));

    sync_fifo #(
        .WIDTH ($bits(wr_req_t)),
        .DEPTH (WFIFO_DEPTH)
    ) u_wfifo (
        .clk_i   (vgaClk),
        .rst_ni  (rstN),
        .push_i  (fifoPush),
        .pop_i   (fifoPop),
        .data_i  (pushReq),
        .data_o  (head),
        .full_o  (fifoFull),
        .empty_o (fifoEmpty),
        .count_o (fifoCount)
    );

    always_comb begin
        fifoPop  = 1'b0;
        memWe    = 1'b0;
        memAddr  = addrHold_q;
        memWdata = wdataHold_q;
        if (!rstN) begin
            memAddr  = '0;
            memWdata = '0;
        end else if (displayActive) begin
            memAddr = {dispBank_q, dispAddr};
        end else if (!fifoEmpty) begin
            fifoPop  = 1'b1;
            memWe    = 1'b1;
            memAddr  = {~dispBank_q, head.addr};
            memWdata = head.data;
        end
    end

    always_ff @(posedge vgaClk) begin
        if (!rstN) begin
            addrHold_q   <= '0;
            wdataHold_q  <= '0;
            actD1_q      <= 1'b0;
            pixelOut_q   <= '0;
            pixelValid_q <= 1'b0;
        end else begin
            addrHold_q   <= memAddr;
            wdataHold_q  <= memWdata;
            actD1_q      <= displayActive;
            pixelOut_q   <= actD1_q ? memRdata : '0;
            pixelValid_q <= actD1_q;
        end
    end

    always_ff @(posedge vgaClk) begin
        if (!rstN) begin
            state_q       <= WRITING;
            swapPending_q <= 1'b0;
            dispBank_q    <= 1'b0;
        end else begin
            case (state_q)
                WRITING: begin
                    if (wrFrameDone) begin
                        state_q       <= SWAP_WAIT;
                        swapPending_q <= 1'b1;
                    end
                end
                SWAP_WAIT: begin
                    if (frameEnd && drained) begin
                        state_q       <= WRITING;
                        swapPending_q <= 1'b0;
                        dispBank_q    <= ~dispBank_q;
                    end
                end
                default: begin
                    state_q       <= WRITING;
                    swapPending_q <= 1'b0;
                end
            endcase
        end
    end

    assign swapPending = swapPending_q;
    assign dispBank    = dispBank_q;
    assign pixelOut    = pixelOut_q;
    assign pixelValid  = pixelValid_q;

endmodule

// File: tb/tb_fb_access_arbiter.sv
// Randomised bench for fb_access_arbiter against a queue-based transaction model.
module tb_fb_access_arbiter;

    localparam int IMG_W    = 320;
    localparam int NPIX     = 320 * 240;
    localparam int BANK_OFS = 131072;

    logic        vgaClk = 1'b0;
    logic        rstN;
    logic [9:0]  hCount, vCount;
    logic        displayActive, frameEnd, wrValid, wrReady, wrFrameDone;
    logic [16:0] wrAddr;
    logic [7:0]  wrData;
    logic        swapPending, dispBank, pixelValid, memWe;
    logic [7:0]  pixelOut, memWdata, memRdata;
    logic [17:0] memAddr;

    always #5 vgaClk = ~vgaClk;

    fb_access_arbiter #(.WFIFO_DEPTH(4)) dut (
        .vgaClk        (vgaClk),
        .rstN          (rstN),
        .hCount        (hCount),
        .vCount        (vCount),
        .displayActive (displayActive),
        .frameEnd      (frameEnd),
        .wrValid       (wrValid),
        .wrReady       (wrReady),
        .wrAddr        (wrAddr),
        .wrData        (wrData),
        .wrFrameDone   (wrFrameDone),
        .swapPending   (swapPending),
        .dispBank      (dispBank),
        .pixelOut      (pixelOut),
        .pixelValid    (pixelValid),
        .memAddr       (memAddr),
        .memWe         (memWe),
        .memWdata      (memWdata),
        .memRdata      (memRdata)
    );

    // Bench-side RAM with registered read; preload port for directed content.
    bit   [7:0]  ram [0:262143];
    logic        pre_we = 1'b0;
    logic [17:0] pre_addr = '0;
    logic [7:0]  pre_data = '0;

    always @(posedge vgaClk) begin
        if (pre_we) ram[pre_addr] <= pre_data;
        if (memWe)  ram[memAddr]  <= memWdata;
        memRdata <= ram[memAddr];
    end

    int n_checks = 0;
    int n_fail   = 0;

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at t=%0t", tag, got, exp, $time);
        end
    endtask

    // Reference model: pending writes as a queue, bank/pending flags, expected memory.
    typedef struct { int addr; int data; } req_t;
    req_t       mq[$];
    bit   [7:0] expm [0:262143];
    int         written[$];
    int m_bank = 0, m_pend = 0, m_last = 0;
    int m_pv = 0, m_po = 0, p1v = 0, p1d = 0;

    task automatic cycle();
        int exp_ready, exp_we, exp_addr, exp_wd, dsp;
        exp_ready = (rstN && !m_pend && mq.size() < 4) ? 1 : 0;
        exp_we    = 0;
        exp_addr  = m_last;
        exp_wd    = 0;
        dsp       = m_bank * BANK_OFS + (int'(vCount) / 2) * IMG_W + int'(hCount) / 2;
        if (!rstN) begin
            exp_addr = 0;
        end else if (displayActive) begin
            exp_addr = dsp;
        end else if (mq.size() > 0) begin
            exp_we   = 1;
            exp_addr = (1 - m_bank) * BANK_OFS + mq[0].addr;
            exp_wd   = mq[0].data;
        end

        @(negedge vgaClk);
        check_eq("wrReady",     {31'd0, wrReady},     exp_ready);
        check_eq("memWe",       {31'd0, memWe},       exp_we);
        check_eq("memAddr",     {14'd0, memAddr},     exp_addr);
        if (exp_we != 0) check_eq("memWdata", {24'd0, memWdata}, exp_wd);
        check_eq("swapPending", {31'd0, swapPending}, m_pend);
        check_eq("dispBank",    {31'd0, dispBank},    m_bank);
        check_eq("pixelValid",  {31'd0, pixelValid},  m_pv);
        check_eq("pixelOut",    {24'd0, pixelOut},    m_po);

        if (!rstN) begin
            mq.delete();
            m_bank = 0; m_pend = 0; m_last = 0;
            m_pv = 0; m_po = 0; p1v = 0; p1d = 0;
        end else begin
            m_pv = p1v;
            m_po = p1d;
            p1v  = displayActive ? 1 : 0;
            p1d  = displayActive ? int'(expm[dsp]) : 0;
            m_last = exp_addr;
            if (exp_we != 0) begin
                expm[exp_addr] = 8'(exp_wd);
                written.push_back(exp_addr);
                void'(mq.pop_front());
            end
            if (wrValid && exp_ready != 0) mq.push_back('{int'(wrAddr), int'(wrData)});
            if (m_pend == 0) begin
                if (wrFrameDone) m_pend = 1;
            end else if (frameEnd && mq.size() == 0) begin
                m_pend = 0;
                m_bank = 1 - m_bank;
            end
        end
        @(posedge vgaClk);
        #1;
    endtask

    task automatic drive(input bit act, input bit wv);
        displayActive = act;
        if (act) begin
            hCount = 10'($urandom_range(0, 639));
            vCount = 10'($urandom_range(0, 479));
        end else begin
            hCount = 10'($urandom_range(640, 799));
            vCount = 10'($urandom_range(0, 524));
        end
        wrValid = wv;
        wrAddr  = 17'($urandom_range(0, NPIX - 1));
        wrData  = 8'($urandom_range(0, 255));
        cycle();
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        rstN = 1'b0; displayActive = 1'b0; frameEnd = 1'b0; wrFrameDone = 1'b0;
        wrValid = 1'b1; wrAddr = '0; wrData = '0; hCount = '0; vCount = '0;
        pre_we = 1'b1; pre_addr = 18'(1 * IMG_W + 2); pre_data = 8'hA5;
        expm[1 * IMG_W + 2] = 8'hA5;
        @(posedge vgaClk); #1;
        pre_we = 1'b0;

        // Reset held with a willing writer.
        repeat (3) drive(1'b0, 1'b1);
        rstN = 1'b1;
        drive(1'b0, 1'b0);

        // Directed display fetch at (5,3).
        displayActive = 1'b1; hCount = 10'd5; vCount = 10'd3; wrValid = 1'b0;
        cycle();
        repeat (3) drive(1'b0, 1'b0);

        // Display priority: four writes buffered, fifth refused, then drained in order.
        repeat (5) drive(1'b1, 1'b1);
        repeat (6) drive(1'b0, 1'b0);

        // One entry queued, then continuous push/pop through blanking.
        drive(1'b1, 1'b1);
        repeat (100) drive(1'b0, 1'b1);
        repeat (3) drive(1'b0, 1'b0);

        // Swap after drain; frame-done coincides with the last push.
        drive(1'b1, 1'b1);
        wrFrameDone = 1'b1; drive(1'b1, 1'b1); wrFrameDone = 1'b0;
        repeat (3) drive(1'b0, 1'b0);
        frameEnd = 1'b1; drive(1'b0, 1'b0); frameEnd = 1'b0;
        drive(1'b0, 1'b1);
        repeat (2) drive(1'b0, 1'b0);

        // Reset while waiting to swap with entries queued.
        repeat (3) drive(1'b1, 1'b1);
        wrFrameDone = 1'b1; drive(1'b1, 1'b0); wrFrameDone = 1'b0;
        rstN = 1'b0; drive(1'b0, 1'b0); rstN = 1'b1;
        repeat (5) drive(1'b0, 1'b0);

        // Deferred swap: frameEnd while non-empty, then swap on the final pop.
        repeat (3) drive(1'b1, 1'b1);
        wrFrameDone = 1'b1; drive(1'b1, 1'b0);
        drive(1'b1, 1'b0); wrFrameDone = 1'b0;
        frameEnd = 1'b1; drive(1'b1, 1'b0); frameEnd = 1'b0;
        repeat (2) drive(1'b0, 1'b0);
        frameEnd = 1'b1; drive(1'b0, 1'b0); frameEnd = 1'b0;
        repeat (2) drive(1'b0, 1'b1);

        // Mixed random traffic.
        for (int i = 0; i < 2000; i++) begin
            frameEnd    = ($urandom_range(0, 39) == 0);
            wrFrameDone = ($urandom_range(0, 29) == 0);
            rstN        = ($urandom_range(0, 499) != 0);
            drive($urandom_range(0, 9) < 6, 1'($urandom_range(0, 1)));
        end
        rstN = 1'b1; frameEnd = 1'b0; wrFrameDone = 1'b0;
        repeat (8) drive(1'b0, 1'b0);

        // Memory scoreboard over every address the model wrote.
        foreach (written[i]) begin
            check_eq("ramData", {24'd0, ram[written[i]]}, {24'd0, expm[written[i]]});
        end

        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end

endmodule
